// File: rtl/pin_change_irq_pkg.sv
// rtl/pin_change_irq_pkg.sv - register map and group constants for the pin-change interrupt block
package pin_change_irq_pkg;

  localparam logic [31:0] PCIFR_ADDR  = 32'h2000_003B;
  localparam logic [31:0] PCICR_ADDR  = 32'h2000_0068;
  localparam logic [31:0] PCMSK0_ADDR = 32'h2000_006B;
  localparam logic [31:0] PCMSK1_ADDR = 32'h2000_006C;
  localparam logic [31:0] PCMSK2_ADDR = 32'h2000_006D;

  localparam logic [31:0] PCIFR_WORD  = {PCIFR_ADDR[31:2], 2'b00};
  localparam logic [31:0] PCICR_WORD  = {PCICR_ADDR[31:2], 2'b00};
  localparam logic [31:0] PCMSK_WORD  = {PCMSK1_ADDR[31:2], 2'b00};

  localparam int          PCINT_GROUPS = 3;
  localparam logic [7:0]  PORTC_VALID  = 8'h7F;

  function automatic logic word_hit(input logic [31:0] addr, input logic [31:0] word);
    return addr[31:2] == word[31:2];
  endfunction

endpackage

// File: rtl/pin_change_irq_pcint_group.sv
// rtl/pin_change_irq_pcint_group.sv - one port group: pad sampling, change detect, flag and irq
// PCINT_SYNC_EN selects a two-flop synchroniser instead of a single sampling register.
module pcint_group (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pins,
  input  logic [7:0] mask,
  input  logic       enable,
  input  logic       clear,
  output logic       flag,
  output logic       irq
);

  logic [7:0] s;
  logic [7:0] prev;
  logic       set;

`ifdef PCINT_SYNC_EN
  logic [7:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      s    <= '0;
    end else begin
      meta <= pins;
      s    <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) s <= '0;
    else        s <= pins;
  end
`endif

  assign set = |((s ^ prev) & mask);

  // A detected change wins over any clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= '0;
      flag <= 1'b0;
    end else begin
      prev <= s;
      if (set)        flag <= 1'b1;
      else if (clear) flag <= 1'b0;
    end
  end

  assign irq = flag & enable;

endmodule

// File: rtl/pin_change_irq.sv
// rtl/pin_change_irq.sv - PCINT controller top: bus decode, PCICR/PCMSK registers, three groups
// Build with PCINT_SYNC_EN for asynchronous pads.
module pin_change_irq
  import pin_change_irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic [7:0]  pin_in_b,
  input  logic [7:0]  pin_in_c,
  input  logic [7:0]  pin_in_d,
  input  logic [2:0]  pcint_ack,
  output logic [2:0]  pcint_irq
);

  logic [2:0] pcicr;
  logic [7:0] pcmsk0;
  logic [7:0] pcmsk1;
  logic [7:0] pcmsk2;
  logic [2:0] pcifr;
  logic [2:0] w1c;

  logic sel_if, sel_cr, sel_msk, sel, wr;
  logic unused_bits;

  assign sel_if  = word_hit(mem_addr, PCIFR_WORD);
  assign sel_cr  = word_hit(mem_addr, PCICR_WORD);
  assign sel_msk = word_hit(mem_addr, PCMSK_WORD);
  assign sel     = sel_if | sel_cr | sel_msk;
  assign wr      = mem_valid && sel && (|mem_wstrb);

  assign unused_bits = ^{mem_addr[1:0], mem_wdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcicr     <= '0;
      pcmsk0    <= '0;
      pcmsk1    <= '0;
      pcmsk2    <= '0;
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= mem_valid && sel;
      if (wr && sel_cr) begin
        if (mem_wstrb[0]) pcicr  <= mem_wdata[2:0];
        if (mem_wstrb[3]) pcmsk0 <= mem_wdata[31:24];
      end
      if (wr && sel_msk) begin
        if (mem_wstrb[0]) pcmsk1 <= mem_wdata[7:0] & PORTC_VALID;
        if (mem_wstrb[1]) pcmsk2 <= mem_wdata[15:8];
      end
    end
  end

  assign w1c = (wr && sel_if && mem_wstrb[3]) ? mem_wdata[26:24] : 3'b000;

  always_comb begin
    mem_rdata = '0;
    if (sel_if)  mem_rdata = {5'b0, pcifr, 24'h0};
    if (sel_cr)  mem_rdata = {pcmsk0, 16'h0, 5'b0, pcicr};
    if (sel_msk) mem_rdata = {16'h0, pcmsk2, pcmsk1};
  end

  pcint_group u_grp0 (
    .clk(clk), .rst_n(rst_n), .pins(pin_in_b), .mask(pcmsk0),
    .enable(pcicr[0]), .clear(w1c[0] | pcint_ack[0]), .flag(pcifr[0]), .irq(pcint_irq[0])
  );

  pcint_group u_grp1 (
    .clk(clk), .rst_n(rst_n), .pins(pin_in_c & PORTC_VALID), .mask(pcmsk1),
    .enable(pcicr[1]), .clear(w1c[1] | pcint_ack[1]), .flag(pcifr[1]), .irq(pcint_irq[1])
  );

  pcint_group u_grp2 (
    .clk(clk), .rst_n(rst_n), .pins(pin_in_d), .mask(pcmsk2),
    .enable(pcicr[2]), .clear(w1c[2] | pcint_ack[2]), .flag(pcifr[2]), .irq(pcint_irq[2])
  );

endmodule
